// File: rtl/dmem_responder.sv
// Doubleword-organised data memory responder. One request in flight at a time,
// with a fixed request-to-response latency and no response backpressure.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// WAIT  | request latched, latency down-counter running
// RESP  | single-cycle response pulse, back to IDLE next
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateType;

    stateType    state;
    logic [3:0]  cnt;
    logic        latWrite;
    logic [1:0]  latSize;
    logic [63:0] latAddr;
    logic [63:0] latWdata;

    logic [63:0] mem [DEPTH];

    logic          accept;
    logic          enterResp;
    logic          cmdWrite;
    logic [1:0]    cmdSize;
    logic [63:0]   cmdAddr;
    logic [63:0]   cmdWdata;
    logic [AW-1:0] cmdIdx;
    logic [2:0]    offset;
    logic          misaligned;
    logic          outOfRange;
    logic          cmdErr;
    logic [7:0]    laneMask;
    logic [7:0]    byteMask;
    logic [63:0]   shiftedData;
    logic [63:0]   curWord;
    logic [63:0]   mergedWord;
    logic [63:0]   loadData;
    logic          memWe;

    assign accept    = (state == IDLE) && req_valid;
    assign enterResp = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd1));

    // With LATENCY=1 the commit edge is the acceptance edge, so the live request is used.
    always_comb begin
        cmdWrite = latWrite;
        cmdSize  = latSize;
        cmdAddr  = latAddr;
        cmdWdata = latWdata;
        if (state == IDLE) begin
            cmdWrite = req_write;
            cmdSize  = req_size;
            cmdAddr  = req_addr;
            cmdWdata = req_wdata;
        end
    end

    assign cmdIdx     = cmdAddr[3 +: AW];
    assign offset     = cmdAddr[2:0];
    assign outOfRange = |(cmdAddr >> (3 + AW));

    always_comb begin
        misaligned = 1'b0;
        laneMask   = 8'h01;
        case (cmdSize)
            2'b00: begin misaligned = 1'b0;        laneMask = 8'h01; end
            2'b01: begin misaligned = offset[0];   laneMask = 8'h03; end
            2'b10: begin misaligned = |offset[1:0]; laneMask = 8'h0F; end
            2'b11: begin misaligned = |offset;     laneMask = 8'hFF; end
            default: begin misaligned = 1'b1;      laneMask = 8'h00; end
        endcase
    end

    assign cmdErr      = misaligned || outOfRange;
    assign byteMask    = laneMask << offset;
    assign shiftedData = cmdWdata << {offset, 3'b000};
    assign curWord     = mem[cmdIdx];

    always_comb begin
        mergedWord = curWord;
        for (int b = 0; b < 8; b++) begin
            if (byteMask[b]) mergedWord[8*b +: 8] = shiftedData[8*b +: 8];
        end
    end

    assign loadData = (!cmdWrite && !cmdErr) ? curWord : 64'd0;
    assign memWe    = enterResp && cmdWrite && !cmdErr && !reset;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (memWe) mem[cmdIdx] <= mergedWord;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            latWrite   <= 1'b0;
            latSize    <= 2'b00;
            latAddr    <= 64'd0;
            latWdata   <= 64'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            if (enterResp) begin
                resp_valid <= 1'b1;
                resp_rdata <= loadData;
                resp_err   <= cmdErr;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        latWrite  <= req_write;
                        latSize   <= req_size;
                        latAddr   <= req_addr;
                        latWdata  <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    cnt       <= 4'd0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for function/boundary cases, LATENCY=1 instance for throughput.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        reqValid, reqReady, reqWrite, respValid, respErr;
    logic [1:0]  reqSize;
    logic [63:0] reqAddr, reqWdata, respRdata;

    logic        r1Valid, r1Ready, r1Write, r1RespValid, r1Err;
    logic [1:0]  r1Size;
    logic [63:0] r1Addr, r1Wdata, r1Rdata;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
        .req_size(reqSize), .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValid), .resp_rdata(respRdata), .resp_err(respErr)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(r1Valid), .req_ready(r1Ready), .req_write(r1Write),
        .req_size(r1Size), .req_addr(r1Addr), .req_wdata(r1Wdata),
        .resp_valid(r1RespValid), .resp_rdata(r1Rdata), .resp_err(r1Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReq(input string tag, input logic w, input logic [1:0] sz,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] expData, input logic expErr);
        int n;
        n = 0;
        while (!reqReady && n < 20) begin tick(); n++; end
        chk({tag, " ready"}, 64'(reqReady), 64'd1);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqAddr = a; reqWdata = wd;
        tick();
        reqValid = 1'b0;
        chk({tag, " busy"}, 64'(reqReady), 64'd0);
        n = 1;
        while (!respValid && n < 20) begin tick(); n++; end
        chk({tag, " latency"}, 64'(n), 64'd2);
        chk({tag, " rdata"}, respRdata, expData);
        chk({tag, " err"}, 64'(respErr), 64'(expErr));
        tick();
        chk({tag, " idle"}, {61'd0, respValid, respErr, reqReady}, 64'd1);
        chk({tag, " idle rdata"}, respRdata, 64'd0);
    endtask

    initial begin
        int quiet;
        reset = 1'b1;
        reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqAddr = 64'd0; reqWdata = 64'd0;
        r1Valid = 1'b0; r1Write = 1'b0; r1Size = 2'b00; r1Addr = 64'd0; r1Wdata = 64'd0;
        tick();
        chk("reset ready", 64'(reqReady), 64'd1);
        chk("reset outs", {62'd0, respValid, respErr}, 64'd0);
        chk("reset rdata", respRdata, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        doReq("st d 0x10", 1'b1, 2'b11, 64'h10, 64'h1122334455667788, 64'd0, 1'b0);
        doReq("ld 0x10 a", 1'b0, 2'b11, 64'h10, 64'd0, 64'h1122334455667788, 1'b0);
        doReq("st b 0x13", 1'b1, 2'b00, 64'h13, 64'hFFFFFFFFFFFFFFAB, 64'd0, 1'b0);
        doReq("ld 0x10 b", 1'b0, 2'b11, 64'h10, 64'd0, 64'h11223344AB667788, 1'b0);
        doReq("st w 0x14", 1'b1, 2'b10, 64'h14, 64'h00000000DEADBEEF, 64'd0, 1'b0);
        doReq("ld 0x10 c", 1'b0, 2'b11, 64'h10, 64'd0, 64'hDEADBEEFAB667788, 1'b0);
        doReq("st h 0x11", 1'b1, 2'b01, 64'h11, 64'h0000000000005555, 64'd0, 1'b1);
        doReq("st w 0x12", 1'b1, 2'b10, 64'h12, 64'h0000000012121212, 64'd0, 1'b1);
        doReq("ld 0x10 d", 1'b0, 2'b11, 64'h10, 64'd0, 64'hDEADBEEFAB667788, 1'b0);
        doReq("ld 0x200", 1'b0, 2'b11, 64'h200, 64'd0, 64'd0, 1'b1);
        doReq("ld hi addr", 1'b0, 2'b00, 64'h8000000000000010, 64'd0, 64'd0, 1'b1);
        doReq("st d 0x18", 1'b1, 2'b11, 64'h18, 64'h0123456789ABCDEF, 64'd0, 1'b0);

        // Request held through busy period is taken in the IDLE cycle after RESP.
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b11; reqAddr = 64'h10;
        tick();
        chk("held wait ready", 64'(reqReady), 64'd0);
        reqAddr = 64'h18;
        tick();
        chk("held resp valid", 64'(respValid), 64'd1);
        chk("held resp ready", 64'(reqReady), 64'd0);
        chk("held resp rdata", respRdata, 64'hDEADBEEFAB667788);
        tick();
        chk("held idle ready", 64'(reqReady), 64'd1);
        chk("held idle valid", 64'(respValid), 64'd0);
        tick();
        reqValid = 1'b0;
        chk("held 2nd accepted", 64'(reqReady), 64'd0);
        tick();
        chk("held 2nd valid", 64'(respValid), 64'd1);
        chk("held 2nd rdata", respRdata, 64'h0123456789ABCDEF);
        tick();

        // Reset during WAIT of a store discards it.
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b11; reqAddr = 64'h18; reqWdata = 64'hFFFFFFFFFFFFFFFF;
        tick();
        reqValid = 1'b0;
        chk("abort wait ready", 64'(reqReady), 64'd0);
        reset = 1'b1;
        #1;
        chk("abort ready now", 64'(reqReady), 64'd1);
        chk("abort no resp", 64'(respValid), 64'd0);
        tick();
        reset = 1'b0;
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (respValid) quiet++;
        end
        chk("abort silent", 64'(quiet), 64'd0);
        doReq("ld 0x18 kept", 1'b0, 2'b11, 64'h18, 64'd0, 64'h0123456789ABCDEF, 1'b0);
        doReq("st h 0x1E", 1'b1, 2'b01, 64'h1E, 64'h0000000000007777, 64'd0, 1'b0);
        doReq("ld 0x18 half", 1'b0, 2'b11, 64'h18, 64'd0, 64'h7777456789ABCDEF, 1'b0);

        // LATENCY=1: continuous req_valid gives one transaction every two cycles.
        r1Valid = 1'b1; r1Write = 1'b1; r1Size = 2'b11; r1Addr = 64'h8; r1Wdata = 64'hCAFEF00D12345678;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("l1 valid c%0d", k), 64'(r1RespValid), 64'(k % 2));
            chk($sformatf("l1 ready c%0d", k), 64'(r1Ready), 64'(1 - (k % 2)));
        end
        r1Write = 1'b0;
        tick();
        r1Valid = 1'b0;
        chk("l1 load valid", 64'(r1RespValid), 64'd1);
        chk("l1 load rdata", r1Rdata, 64'hCAFEF00D12345678);
        chk("l1 load err", 64'(r1Err), 64'd0);
        tick();
        chk("l1 after valid", 64'(r1RespValid), 64'd0);
        chk("l1 after rdata", r1Rdata, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
